// File: rtl/mips_cpu_mul_div.sv
// Iterative MIPS HI/LO multiply/divide unit for the execute stage.
// Optional macro MIPS_CPU_MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU.
module mips_cpu_mul_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_p;
    logic [31:0] r_opnd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_sgn_op;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_madd;
    logic [63:0] w_mstep;
    logic [63:0] w_mres;
    logic [32:0] w_dsub;
    logic [63:0] w_dstep;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_accept = start & ~r_busy;
    assign w_sgn_op = (op == 3'd0) || (op == 3'd2);
    assign w_a_mag  = (w_sgn_op && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag  = (w_sgn_op && b[31]) ? (~b + 32'd1) : b;

    // Multiply step: r_p = {partial upper, remaining multiplier bits}
    assign w_madd  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mstep = {w_madd, r_p[31:1]};
    assign w_mres  = r_neg_q ? (~w_mstep + 64'd1) : w_mstep;

    // Divide step: r_p = {remainder, dividend/quotient shift register}
    assign w_dsub  = r_p[63:31] - {1'b0, r_opnd};
    assign w_dstep = w_dsub[32] ? {r_p[62:0], 1'b0}
                                : {w_dsub[31:0], r_p[30:0], 1'b1};
    assign w_quo   = r_neg_q ? (~w_dstep[31:0] + 32'd1) : w_dstep[31:0];
    assign w_rem   = r_neg_r ? (~w_dstep[63:32] + 32'd1) : w_dstep[63:32];

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_fast_prod;

    assign w_a_ext     = (op == 3'd0) ? {{32{a[31]}}, a} : {32'd0, a};
    assign w_b_ext     = (op == 3'd0) ? {{32{b[31]}}, b} : {32'd0, b};
    assign w_fast_prod = w_a_ext * w_b_ext;
`endif

    // Sequencer: accept requests, iterate one bit per cycle, write HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_p     <= 64'd0;
            r_opnd  <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_MUL: begin
                    r_p   <= w_mstep;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        {r_hi, r_lo} <= w_mres;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_FINISH;
                    end
                end
                S_DIV: begin
                    r_p   <= w_dstep;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_lo    <= w_quo;
                        r_hi    <= w_rem;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                default: begin
                    // IDLE and FINISH both accept a new request
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        unique case (op)
                            3'd0, 3'd1: begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                                {r_hi, r_lo} <= w_fast_prod;
                                r_done       <= 1'b1;
                                r_state      <= S_FINISH;
`else
                                r_p     <= {32'd0, w_b_mag};
                                r_opnd  <= w_a_mag;
                                r_neg_q <= w_sgn_op & (a[31] ^ b[31]);
                                r_cnt   <= 5'd0;
                                r_busy  <= 1'b1;
                                r_state <= S_MUL;
`endif
                            end
                            3'd2, 3'd3: begin
                                r_p     <= {32'd0, w_a_mag};
                                r_opnd  <= w_b_mag;
                                r_neg_q <= w_sgn_op & (a[31] ^ b[31]);
                                r_neg_r <= w_sgn_op & a[31];
                                r_cnt   <= 5'd0;
                                r_busy  <= 1'b1;
                                r_state <= S_DIV;
                            end
                            3'd4:    r_hi <= a;
                            3'd5:    r_lo <= a;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_mul_div.sv
// Self-checking bench for mips_cpu_mul_div.
// Directed plan scenarios plus random ops against an arithmetic model.
module tb_mips_cpu_mul_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mips_cpu_mul_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference: architectural HI/LO result from plain arithmetic
    function automatic void model(input logic [2:0] fo,
                                  input logic [31:0] fa,
                                  input logic [31:0] fb);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (fo)
            3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, fa} * {32'd0, fb}; {m_hi, m_lo} = p; end
            3'd2: begin
                if (fb == 32'd0) begin
                    m_lo = fa[31] ? 32'd1 : 32'hFFFFFFFF;
                    m_hi = fa;
                end else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            3'd3: begin
                if (fb == 32'd0) begin
                    m_lo = 32'hFFFFFFFF;
                    m_hi = fa;
                end else begin
                    m_lo = fa / fb;
                    m_hi = fa % fb;
                end
            end
            3'd4: m_hi = fa;
            3'd5: m_lo = fa;
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] fo);
        if (fo <= 3'd1) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
            return 0;
`else
            return 32;
`endif
        end
        if (fo <= 3'd3) return 32;
        return 0;
    endfunction

    function automatic int exp_lat(input logic [2:0] fo);
        if (fo <= 3'd3) return exp_busy(fo) + 1;
        return 0;
    endfunction

    // Issue one request, then observe busy/done until the op settles
    task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int nb,
                         output int nd, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        nb = 0; nd = 0; lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                if (lat == 0) lat = k;
            end
            if ((lat != 0 && k > lat) || (lat == 0 && !busy && k >= 2)) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mthi_mtlo();
        int nb = 0, nd = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(negedge clk);
        nb += int'(busy); nd += int'(done);
        op = 3'd5; a = 32'h9ABCDEF0;
        @(negedge clk);
        nb += int'(busy); nd += int'(done);
        start = 1'b0;
        @(negedge clk);
        nb += int'(busy); nd += int'(done);
        model(3'd4, 32'h12345678, 32'd0);
        model(3'd5, 32'h9ABCDEF0, 32'd0);
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
        checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo got %h want 9abcdef0", lo); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL mtx_busy got %0d want 0", nb); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mtx_done got %0d want 0", nd); end
    endtask

    task automatic test_multu();
        int nb, nd, lat;
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, nd, lat);
        model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
        checks++; if (nb !== exp_busy(3'd1)) begin errors++; $display("FAIL multu_busy got %0d want %0d", nb, exp_busy(3'd1)); end
        checks++; if (lat !== exp_lat(3'd1)) begin errors++; $display("FAIL multu_lat got %0d want %0d", lat, exp_lat(3'd1)); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL multu_done got %0d want 1", nd); end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [6];
        logic [31:0] t_a  [6];
        logic [31:0] t_b  [6];
        logic [31:0] t_hi [6];
        logic [31:0] t_lo [6];
        int nb, nd, lat;
        t_op = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd0, 3'd2};
        t_a  = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFFFB, 32'h80000000, 32'd5};
        t_b  = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000000, 32'd0};
        t_hi = '{32'hFFFFFFFF, 32'd0, 32'd100, 32'hFFFFFFFB, 32'h40000000, 32'd5};
        t_lo = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], nb, nd, lat);
            model(t_op[i], t_a[i], t_b[i]);
            checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, hi, t_hi[i]); end
            checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, lo, t_lo[i]); end
            checks++; if (nb !== exp_busy(t_op[i])) begin errors++; $display("FAIL dir%0d_busy got %0d want %0d", i, nb, exp_busy(t_op[i])); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL dir%0d_done got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_busy_ignore();
        int nb = 0, lat = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) nb++;
            if (done) begin lat = k; break; end
            if (k == 10) begin start = 1'b1; op = 3'd5; a = 32'hDEAD; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        model(3'd3, 32'd1000, 32'd7);
        checks++; if (lo !== 32'd142) begin errors++; $display("FAIL ignore_lo got %0d want 142", lo); end
        checks++; if (hi !== 32'd6) begin errors++; $display("FAIL ignore_hi got %0d want 6", hi); end
        checks++; if (nb !== 32) begin errors++; $display("FAIL ignore_busy got %0d want 32", nb); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_lat got %0d want 33", lat); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ignore_done_width got %b want 0", done); end
    endtask

    task automatic test_reset_abort();
        int nb = 0, nd = 0, lat;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 16; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo got %h want 0", lo); end
        for (int k = 0; k < 40; k++) begin
            nb += int'(busy); nd += int'(done);
            @(negedge clk);
        end
        checks++; if (nb + nd !== 0) begin errors++; $display("FAIL abort_quiet got busy %0d done %0d want 0", nb, nd); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hold got %h want 0", {hi, lo}); end
        do_op(3'd0, 32'hFFFFFFFD, 32'd5, nb, nd, lat);
        model(3'd0, 32'hFFFFFFFD, 32'd5);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mneg_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mneg_lo got %h want fffffff1", lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        int k;
        x = $urandom; y = $urandom;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k <= 60 && done !== 1'b1; k++) @(negedge clk);
        model(3'd1, x, y);
        checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b_first got %h want %h", {hi, lo}, {m_hi, m_lo}); end
        x = $urandom; y = $urandom | 32'd1;
        start = 1'b1; op = 3'd3; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy); end
        for (k = 1; k <= 60 && done !== 1'b1; k++) @(negedge clk);
        model(3'd3, x, y);
        checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b_second got %h want %h", {hi, lo}, {m_hi, m_lo}); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        int nb, nd, lat;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom);
            x = $urandom; y = $urandom;
            if ($urandom % 4 == 0) y = 32'd0;
            if ($urandom % 5 == 0) x = 32'h80000000;
            if ($urandom % 5 == 0) y = 32'hFFFFFFFF;
            do_op(o, x, y, nb, nd, lat);
            model(o, x, y);
            checks++;
            if ({hi, lo} !== {m_hi, m_lo} || nb !== exp_busy(o) || lat !== exp_lat(o)) begin
                errors++;
                $display("FAIL rnd%0d op%0d a=%h b=%h got hi=%h lo=%h busy=%0d lat=%0d want hi=%h lo=%h busy=%0d lat=%0d",
                         i, o, x, y, hi, lo, nb, lat, m_hi, m_lo, exp_busy(o), exp_lat(o));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_multu();
        test_div();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
